// File: rtl/hc595_chain_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_chain_arbiter_if
//  Description : Bundle between two frame requesters and the 74HC595 chain
//                arbiter. It carries the req/data/ack handshake for both
//                requesters, the status outputs, and the three chain pins.
//  Revision    : 1.0  initial release
// ============================================================================
interface hc595_chain_arbiter_if #(
   parameter int DATA_W = 16
);
   logic              req0;
   logic [DATA_W-1:0] data0;
   logic              ack0;
   logic              req1;
   logic [DATA_W-1:0] data1;
   logic              ack1;
   logic              busy;
   logic              grant_id;
   logic              srclk;
   logic              rclk;
   logic              ser;

   // Requester / board side: drives requests, observes everything else
   modport master (
      output req0, data0, req1, data1,
      input  ack0, ack1, busy, grant_id, srclk, rclk, ser
   );

   // Arbiter side
   modport slave (
      input  req0, data0, req1, data1,
      output ack0, ack1, busy, grant_id, srclk, rclk, ser
   );
endinterface
`default_nettype wire

// File: rtl/hc595_chain_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_chain_arbiter
//  Description : Shares one 74HC595 serial chain between two requesters.
//                Round-robin grant in IDLE, word captured with a one-cycle
//                ack, shifted out MSB-first with a CLK_DIV-cycle half period
//                on srclk, then latched with a single rclk pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module hc595_chain_arbiter #(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 2
) (
   input  wire logic             clk_i,
   input  wire logic             rst_i,
   hc595_chain_arbiter_if.slave  bus
);

   localparam int BIT_W = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;
   localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   // The MSB goes straight to ser at grant time, so only the remaining
   // DATA_W-1 bits need to be held for shifting.
   localparam int SH_W  = DATA_W - 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SHIFT_LO = 3'd1;
   localparam logic [2:0] S_SHIFT_HI = 3'd2;
   localparam logic [2:0] S_LATCH_HI = 3'd3;
   localparam logic [2:0] S_LATCH_LO = 3'd4;

   logic [2:0]       state_q,    state_d;
   logic [PH_W-1:0]  phase_q,    phase_d;
   logic [BIT_W-1:0] bit_q,      bit_d;
   logic [SH_W-1:0]  shift_q,    shift_d;
   logic             ptr_q,      ptr_d;
   logic             ser_q,      ser_d;
   logic             srclk_q,    srclk_d;
   logic             rclk_q,     rclk_d;
   logic             ack0_q,     ack0_d;
   logic             ack1_q,     ack1_d;
   logic             busy_q,     busy_d;
   logic             grant_id_q, grant_id_d;

   logic              w_phase_done;
   logic              w_last_bit;
   logic              w_grant;
   logic              w_winner;
   logic [DATA_W-1:0] w_win_data;

   // Arbitration and timing qualifiers shared by both combinational processes
   always_comb begin
      w_phase_done = (phase_q == PH_LAST);
      w_last_bit   = (bit_q == BIT_LAST);
      w_grant      = (state_q == S_IDLE) && (bus.req0 || bus.req1);
      // Contention goes to the pointer; otherwise whoever is asking wins
      w_winner     = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
      w_win_data   = w_winner ? bus.data1 : bus.data0;
   end

   // State register plus all registered datapath and output flops
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         ptr_q      <= 1'b0;
         ser_q      <= 1'b0;
         srclk_q    <= 1'b0;
         rclk_q     <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         busy_q     <= 1'b0;
         grant_id_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         ser_q      <= ser_d;
         srclk_q    <= srclk_d;
         rclk_q     <= rclk_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         busy_q     <= busy_d;
         grant_id_q <= grant_id_d;
      end
   end

   // Next-state: every non-IDLE state lasts one full phase-counter period
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (w_grant) state_d = S_SHIFT_LO;
         end
         S_SHIFT_LO: begin
            if (w_phase_done) state_d = S_SHIFT_HI;
         end
         S_SHIFT_HI: begin
            if (w_phase_done) state_d = w_last_bit ? S_LATCH_HI : S_SHIFT_LO;
         end
         S_LATCH_HI: begin
            if (w_phase_done) state_d = S_LATCH_LO;
         end
         S_LATCH_LO: begin
            if (w_phase_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; pins are decoded from the next state so the
   // registered outputs line up exactly with the state they belong to
   always_comb begin
      phase_d    = '0;
      bit_d      = bit_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      ser_d      = ser_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      grant_id_d = grant_id_q;
      srclk_d    = (state_d == S_SHIFT_HI);
      rclk_d     = (state_d == S_LATCH_HI);
      busy_d     = (state_d != S_IDLE);

      if (state_q != S_IDLE) begin
         phase_d = w_phase_done ? '0 : phase_q + PH_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (w_grant) begin
               shift_d    = w_win_data[SH_W-1:0];
               ser_d      = w_win_data[DATA_W-1];
               bit_d      = '0;
               ack0_d     = ~w_winner;
               ack1_d     = w_winner;
               grant_id_d = w_winner;
               ptr_d      = ~w_winner;
            end
         end
         S_SHIFT_HI: begin
            // Present the next bit only once srclk has dropped again
            if (w_phase_done && !w_last_bit) begin
               ser_d   = shift_q[SH_W-1];
               shift_d = shift_q << 1;
               bit_d   = bit_q + BIT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign bus.ack0     = ack0_q;
   assign bus.ack1     = ack1_q;
   assign bus.busy     = busy_q;
   assign bus.grant_id = grant_id_q;
   assign bus.srclk    = srclk_q;
   assign bus.rclk     = rclk_q;
   assign bus.ser      = ser_q;

endmodule
`default_nettype wire

// File: tb/tb_hc595_chain_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hc595_chain_arbiter
//  Description : Directed self-checking bench for hc595_chain_arbiter.
//                u_dut0 uses CLK_DIV=2, u_dut1 uses CLK_DIV=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hc595_chain_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   hc595_chain_arbiter_if #(.DATA_W(16)) b0 ();
   hc595_chain_arbiter_if #(.DATA_W(16)) b1 ();

   hc595_chain_arbiter #(.DATA_W(16), .CLK_DIV(2)) u_dut0 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b0)
   );

   hc595_chain_arbiter #(.DATA_W(16), .CLK_DIV(1)) u_dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b1)
   );

   always #5 clk = ~clk;

   // Results of the most recent frame observation
   logic [15:0] c_bits;
   int          c_rises, c_rclk_hi, c_rclk_pulses, c_busy;
   int          c_ack0, c_ack1, c_pat_err, c_timeout;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      b0.req0 = 1'b0; b0.req1 = 1'b0; b0.data0 = '0; b0.data1 = '0;
      b1.req0 = 1'b0; b1.req1 = 1'b0; b1.data0 = '0; b1.data1 = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_reqs();
      step();
      step();
      rst = 1'b0;
   endtask

   // Walks one frame from the current sample until busy drops, recording the
   // pin activity. The srclk/rclk reference pattern assumes the first sample
   // is the ack cycle: srclk = (n/div)%2 over 32*div samples, rclk high for
   // the next div samples.
   task automatic collect(input int sel, input int div);
      logic s, r, bz, sr, a0, a1, prev_s, prev_r, exp_s, exp_r;
      int   n;
      c_bits = '0; c_rises = 0; c_rclk_hi = 0; c_rclk_pulses = 0; c_busy = 0;
      c_ack0 = 0; c_ack1 = 0; c_pat_err = 0; c_timeout = 0;
      prev_s = 1'b0; prev_r = 1'b0; n = 0;
      bz = (sel != 0) ? b1.busy : b0.busy;
      while (bz && n < 200) begin
         s  = (sel != 0) ? b1.srclk : b0.srclk;
         r  = (sel != 0) ? b1.rclk  : b0.rclk;
         sr = (sel != 0) ? b1.ser   : b0.ser;
         a0 = (sel != 0) ? b1.ack0  : b0.ack0;
         a1 = (sel != 0) ? b1.ack1  : b0.ack1;
         c_busy++;
         if (s && !prev_s) begin
            c_rises++;
            c_bits = {c_bits[14:0], sr};
         end
         if (r) c_rclk_hi++;
         if (r && !prev_r) c_rclk_pulses++;
         if (a0) c_ack0++;
         if (a1) c_ack1++;
         exp_s = (n < 32*div) ? (((n / div) % 2) == 1) : 1'b0;
         exp_r = (n >= 32*div) && (n < 33*div);
         if (s !== exp_s || r !== exp_r) c_pat_err++;
         prev_s = s; prev_r = r; n++;
         step();
         bz = (sel != 0) ? b1.busy : b0.busy;
      end
      if (n >= 200) c_timeout = 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_reqs();
      step();
      step();
      checks++; if (b0.srclk !== 1'b0) begin failures++; $display("FAIL reset_srclk got %b want 0", b0.srclk); end
      checks++; if (b0.rclk !== 1'b0) begin failures++; $display("FAIL reset_rclk got %b want 0", b0.rclk); end
      checks++; if (b0.ser !== 1'b0) begin failures++; $display("FAIL reset_ser got %b want 0", b0.ser); end
      checks++; if (b0.ack0 !== 1'b0 || b0.ack1 !== 1'b0) begin failures++; $display("FAIL reset_ack got %b%b want 00", b0.ack0, b0.ack1); end
      checks++; if (b0.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", b0.busy); end
      checks++; if (b0.grant_id !== 1'b0) begin failures++; $display("FAIL reset_grant_id got %b want 0", b0.grant_id); end
      checks++; if (b1.busy !== 1'b0 || b1.srclk !== 1'b0) begin failures++; $display("FAIL reset_dut1 got busy=%b srclk=%b want 0 0", b1.busy, b1.srclk); end
      rst = 1'b0;
   endtask

   task automatic test_single_frame();
      do_reset();
      b0.req0 = 1'b1; b0.data0 = 16'hA5C3;
      step();
      checks++; if (b0.ack0 !== 1'b1 || b0.busy !== 1'b1) begin failures++; $display("FAIL single_ack got ack0=%b busy=%b want 1 1", b0.ack0, b0.busy); end
      checks++; if (b0.grant_id !== 1'b0) begin failures++; $display("FAIL single_grant_id got %b want 0", b0.grant_id); end
      checks++; if (b0.ser !== 1'b1) begin failures++; $display("FAIL single_first_ser got %b want 1", b0.ser); end
      b0.req0 = 1'b0;
      b0.data0 = 16'h0000;   // must not disturb the frame in flight
      collect(0, 2);
      checks++; if (c_timeout != 0 || c_busy != 68) begin failures++; $display("FAIL single_busy_len got %0d want 68", c_busy); end
      checks++; if (c_bits !== 16'hA5C3 || c_rises != 16) begin failures++; $display("FAIL single_bits got %h/%0d want a5c3/16", c_bits, c_rises); end
      checks++; if (c_rclk_pulses != 1 || c_rclk_hi != 2) begin failures++; $display("FAIL single_rclk got pulses=%0d hi=%0d want 1 2", c_rclk_pulses, c_rclk_hi); end
      checks++; if (c_ack0 != 1 || c_ack1 != 0) begin failures++; $display("FAIL single_ack_count got %0d/%0d want 1/0", c_ack0, c_ack1); end
      checks++; if (c_pat_err != 0) begin failures++; $display("FAIL single_pin_pattern got %0d errors want 0", c_pat_err); end
      checks++; if (b0.ser !== 1'b1 || b0.srclk !== 1'b0 || b0.rclk !== 1'b0) begin failures++; $display("FAIL single_idle_pins got ser=%b srclk=%b rclk=%b want 1 0 0", b0.ser, b0.srclk, b0.rclk); end
   endtask

   task automatic test_contention();
      logic        exp_id;
      logic [15:0] exp_w;
      do_reset();
      b0.req0 = 1'b1; b0.data0 = 16'h1234;
      b0.req1 = 1'b1; b0.data1 = 16'hABCD;
      for (int i = 0; i < 4; i++) begin
         exp_id = (i % 2 == 1);
         exp_w  = exp_id ? 16'hABCD : 16'h1234;
         step();
         checks++; if (b0.grant_id !== exp_id || b0.ack0 !== !exp_id || b0.ack1 !== exp_id) begin failures++; $display("FAIL contention_grant%0d got id=%b ack=%b%b want id=%b", i, b0.grant_id, b0.ack0, b0.ack1, exp_id); end
         if (exp_id) b0.req1 = 1'b0; else b0.req0 = 1'b0;
         step();
         if (exp_id) b0.req1 = 1'b1; else b0.req0 = 1'b1;
         collect(0, 2);
         c_busy++;   // the ack cycle was consumed before collect started
         checks++; if (c_timeout != 0 || c_bits !== exp_w || c_rises != 16 || c_busy != 68) begin failures++; $display("FAIL contention_word%0d got %h rises=%0d busy=%0d want %h 16 68", i, c_bits, c_rises, c_busy, exp_w); end
      end
      b0.req0 = 1'b0; b0.req1 = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      b0.req1 = 1'b1; b0.data1 = 16'h5A5A;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (b0.ack1 !== 1'b1 || b0.grant_id !== 1'b1 || b0.busy !== 1'b1) begin failures++; $display("FAIL b2b_grant%0d got ack1=%b id=%b busy=%b want 1 1 1", k, b0.ack1, b0.grant_id, b0.busy); end
         if (k == 2) b0.req1 = 1'b0;
         collect(0, 2);
         checks++; if (c_timeout != 0 || c_busy != 68 || c_bits !== 16'h5A5A) begin failures++; $display("FAIL b2b_frame%0d got busy=%0d bits=%h want 68 5a5a", k, c_busy, c_bits); end
         checks++; if (b0.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle%0d got busy=%b want 0", k, b0.busy); end
      end
      step();
      checks++; if (b0.busy !== 1'b0 || b0.ack1 !== 1'b0) begin failures++; $display("FAIL b2b_no_extra got busy=%b ack1=%b want 0 0", b0.busy, b0.ack1); end
   endtask

   task automatic test_dropped();
      int acks0;
      int idle_bad;
      do_reset();
      acks0 = 0;
      b0.req1 = 1'b1; b0.data1 = 16'h0F0F;
      step();
      checks++; if (b0.ack1 !== 1'b1) begin failures++; $display("FAIL dropped_ack1 got %b want 1", b0.ack1); end
      b0.req1 = 1'b0;
      for (int i = 0; i < 10; i++) step();
      b0.req0 = 1'b1; b0.data0 = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         step();
         if (b0.ack0) acks0++;
      end
      b0.req0 = 1'b0;
      collect(0, 2);
      checks++; if (acks0 + c_ack0 != 0) begin failures++; $display("FAIL dropped_no_ack0 got %0d want 0", acks0 + c_ack0); end
      checks++; if (c_timeout != 0 || c_rclk_pulses != 1) begin failures++; $display("FAIL dropped_one_latch got %0d want 1", c_rclk_pulses); end
      idle_bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (b0.busy || b0.ack0 || b0.srclk || b0.rclk) idle_bad++;
         step();
      end
      checks++; if (idle_bad != 0) begin failures++; $display("FAIL dropped_bus_idle got %0d active samples want 0", idle_bad); end
   endtask

   task automatic test_reset_mid_frame();
      int   rises;
      int   n;
      int   rclk_seen;
      logic prev_s;
      do_reset();
      b0.req0 = 1'b1; b0.data0 = 16'hA5C3;
      step();
      b0.req0 = 1'b0;
      rises = 0; n = 0; prev_s = 1'b0; rclk_seen = 0;
      while (rises < 7 && n < 100) begin
         if (b0.srclk && !prev_s) rises++;
         if (b0.rclk) rclk_seen++;
         prev_s = b0.srclk;
         if (rises < 7) step();
         n++;
      end
      checks++; if (rises != 7) begin failures++; $display("FAIL midreset_reach7 got %0d want 7", rises); end
      rst = 1'b1;
      step();
      checks++; if (b0.srclk !== 1'b0 || b0.rclk !== 1'b0 || b0.ser !== 1'b0 || b0.busy !== 1'b0) begin failures++; $display("FAIL midreset_pins got srclk=%b rclk=%b ser=%b busy=%b want 0 0 0 0", b0.srclk, b0.rclk, b0.ser, b0.busy); end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (b0.rclk) rclk_seen++;
         step();
      end
      checks++; if (rclk_seen != 0) begin failures++; $display("FAIL midreset_no_latch got %0d want 0", rclk_seen); end
      // The pre-reset grant moved the pointer to 1; reset must return it to 0
      b0.req0 = 1'b1; b0.data0 = 16'h00FF;
      b0.req1 = 1'b1; b0.data1 = 16'hFF00;
      step();
      checks++; if (b0.ack0 !== 1'b1 || b0.ack1 !== 1'b0 || b0.grant_id !== 1'b0) begin failures++; $display("FAIL midreset_pointer got ack=%b%b id=%b want 10 0", b0.ack0, b0.ack1, b0.grant_id); end
      b0.req0 = 1'b0;
      collect(0, 2);
      b0.req1 = 1'b0;
      checks++; if (c_timeout != 0 || c_bits !== 16'h00FF || c_rises != 16 || c_pat_err != 0) begin failures++; $display("FAIL midreset_refill got %h rises=%0d pat=%0d want 00ff 16 0", c_bits, c_rises, c_pat_err); end
      step();
   endtask

   task automatic test_clk_div1();
      do_reset();
      b1.req0 = 1'b1; b1.data0 = 16'hFFFF;
      step();
      checks++; if (b1.ack0 !== 1'b1 || b1.ser !== 1'b1) begin failures++; $display("FAIL div1_ack got ack0=%b ser=%b want 1 1", b1.ack0, b1.ser); end
      b1.req0 = 1'b0;
      collect(1, 1);
      checks++; if (c_timeout != 0 || c_busy != 34) begin failures++; $display("FAIL div1_frame_len got %0d want 34", c_busy); end
      checks++; if (c_pat_err != 0 || c_rises != 16 || c_bits !== 16'hFFFF) begin failures++; $display("FAIL div1_toggle got pat=%0d rises=%0d bits=%h want 0 16 ffff", c_pat_err, c_rises, c_bits); end
      checks++; if (c_rclk_hi != 1 || c_rclk_pulses != 1) begin failures++; $display("FAIL div1_rclk got hi=%0d pulses=%0d want 1 1", c_rclk_hi, c_rclk_pulses); end
   endtask

   initial begin
      clk      = 1'b0;
      rst      = 1'b1;
      checks   = 0;
      failures = 0;
      clear_reqs();
      test_reset();
      test_single_frame();
      test_contention();
      test_back_to_back();
      test_dropped();
      test_reset_mid_frame();
      test_clk_div1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
